// File: rtl/ms_ff_pkg.sv
// Shared types and next-state helpers for the master-slave flip-flop bank.
package ms_ff_pkg;

  // Global storage-cell behaviour selected by the mode input.
  typedef enum logic [1:0] {
    FF_JK = 2'b00,
    FF_SR = 2'b01,
    FF_D  = 2'b10,
    FF_T  = 2'b11
  } ff_mode_t;

  // Input pair {j,k} (or {s,r}) encodings shared by JK and SR evaluation.
  localparam logic [1:0] PAIR_HOLD = 2'b00;
  localparam logic [1:0] PAIR_CLR  = 2'b01;
  localparam logic [1:0] PAIR_SET  = 2'b10;
  localparam logic [1:0] PAIR_BOTH = 2'b11;

  // JK next state for one bit; the both-high case toggles the master.
  function automatic logic jk_next(input logic j, input logic k, input logic m);
    logic nxt;
    case ({j, k})
      PAIR_HOLD: nxt = m;
      PAIR_CLR:  nxt = 1'b0;
      PAIR_SET:  nxt = 1'b1;
      PAIR_BOTH: nxt = ~m;
      default:   nxt = m;
    endcase
    return nxt;
  endfunction

  // SR is JK with the both-high case treated as illegal and therefore held.
  function automatic logic sr_next(input logic s, input logic r, input logic m);
    logic nxt;
    if ({s, r} == PAIR_BOTH) begin
      nxt = m;
    end else begin
      nxt = jk_next(s, r, m);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ms_ff_next.sv
// Combinational next-state cell for one bit of the master register.
module ms_ff_next
  import ms_ff_pkg::*;
(
  input  ff_mode_t mode,
  input  logic     j,
  input  logic     k,
  input  logic     m,
  output logic     nxt,
  output logic     illegal
);

  // Select the next master value and flag S=R=1 while in SR mode.
  always_comb begin
    nxt     = m;
    illegal = 1'b0;
    case (mode)
      FF_JK: nxt = jk_next(j, k, m);
      FF_SR: begin
        nxt     = sr_next(j, k, m);
        illegal = j & k;
      end
      FF_D:    nxt = j;
      FF_T:    nxt = j ? ~m : m;
      default: nxt = m;
    endcase
  end

endmodule

// File: rtl/ms_jk_reg.sv
// Master-slave flip-flop register bank: master evaluates JK/SR/D/T logic,
// slave copies the master one edge later, plus load, change strobe and
// sticky illegal-SR flag.
module ms_jk_reg
  import ms_ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] m_q,
  output logic [WIDTH-1:0] chg,
  output logic             err
);

  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic             r_err;

  ff_mode_t         w_mode;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_illegal;
  logic             w_err_set;

  assign w_mode = ff_mode_t'(mode);

  // One next-state cell per bit; toggle feedback comes from the master.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ms_ff_next u_next (
      .mode    (w_mode),
      .j       (j[gi]),
      .k       (k[gi]),
      .m       (r_m[gi]),
      .nxt     (w_nxt[gi]),
      .illegal (w_illegal[gi])
    );
  end

  // Illegal bits only count when the enabled SR update actually happens.
  assign w_err_set = ~ld & en & (w_mode == FF_SR) & (|w_illegal);

  // Master register: load beats enable beats hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= RESET_VAL;
    end else if (ld) begin
      r_m <= ld_val;
    end else if (en) begin
      r_m <= w_nxt;
    end else begin
      r_m <= r_m;
    end
  end

  // Slave follows the master every edge; chg marks bits the slave flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= RESET_VAL;
      r_chg <= {WIDTH{1'b0}};
    end else begin
      r_q   <= r_m;
      r_chg <= r_m ^ r_q;
    end
  end

  // Sticky error; a new illegal edge outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  assign q     = r_q;
  assign q_bar = ~r_q;
  assign m_q   = r_m;
  assign chg   = r_chg;
  assign err   = r_err;

endmodule

// File: tb/tb_ms_jk_reg.sv
// Scoreboard bench for ms_jk_reg: a reference model pushes the expected
// {m_q,q,q_bar,chg,err} per edge, and each test pops and compares after it.
module tb_ms_jk_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic       ld;
  logic [7:0] ld_val;
  logic       err_clr;
  logic [7:0] q;
  logic [7:0] q_bar;
  logic [7:0] m_q;
  logic [7:0] chg;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] mdl_m;
  logic [7:0] mdl_q;
  logic [7:0] mdl_chg;
  logic       mdl_err;

  logic [40:0] sb[$];
  logic [40:0] exp_v;
  logic [40:0] obs_v;

  ms_jk_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .ld      (ld),
    .ld_val  (ld_val),
    .err_clr (err_clr),
    .q       (q),
    .q_bar   (q_bar),
    .m_q     (m_q),
    .chg     (chg),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_next(input logic [1:0] md, input logic [7:0] jj,
                                             input logic [7:0] kk, input logic [7:0] mm);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case (md)
        2'b00: r[i] = (jj[i] & kk[i]) ? ~mm[i] : (jj[i] ? 1'b1 : (kk[i] ? 1'b0 : mm[i]));
        2'b01: r[i] = (jj[i] & kk[i]) ? mm[i] : (jj[i] ? 1'b1 : (kk[i] ? 1'b0 : mm[i]));
        2'b10: r[i] = jj[i];
        default: r[i] = mm[i] ^ jj[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [40:0] observed();
    return {m_q, q, q_bar, chg, err};
  endfunction

  task automatic model_reset();
    mdl_m = 8'h00; mdl_q = 8'h00; mdl_chg = 8'h00; mdl_err = 1'b0;
    sb.delete();
  endtask

  // Drive one edge of stimulus and push the model's expected result.
  task automatic step(input logic e, input logic [1:0] md, input logic [7:0] jj,
                      input logic [7:0] kk, input logic l, input logic [7:0] lv,
                      input logic ec);
    logic [7:0] nm;
    logic       set;
    en = e; mode = md; j = jj; k = kk; ld = l; ld_val = lv; err_clr = ec;
    nm  = l ? lv : (e ? model_next(md, jj, kk, mdl_m) : mdl_m);
    set = !l && e && (md == 2'b01) && ((jj & kk) != 8'h00);
    mdl_chg = mdl_m ^ mdl_q;
    mdl_q   = mdl_m;
    mdl_m   = nm;
    mdl_err = set ? 1'b1 : (ec ? 1'b0 : mdl_err);
    sb.push_back({mdl_m, mdl_q, ~mdl_q, mdl_chg, mdl_err});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b0; mode = 2'b00; j = 8'h00; k = 8'h00; ld = 1'b0; ld_val = 8'h00; err_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (observed() !== {8'h00, 8'h00, 8'hFF, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_async: got %h expected %h", observed(), {8'h00, 8'h00, 8'hFF, 8'h00, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
      exp_v = sb.pop_front();
      obs_v = observed();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_jk_toggle();
    logic [7:0] want_m;
    step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    void'(sb.pop_front());
    step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    void'(sb.pop_front());
    want_m = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
      want_m = ~want_m;
      exp_v = sb.pop_front();
      obs_v = observed();
      n_checks++;
      if (obs_v !== exp_v || m_q !== want_m || (i > 0 && chg !== 8'hFF)) begin
        n_errors++;
        $display("FAIL jk_toggle[%0d]: got %h expected %h (m_q %h want %h)", i, obs_v, exp_v, m_q, want_m);
      end
    end
  endtask

  task automatic test_sr_illegal();
    step(1'b0, 2'b01, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
    void'(sb.pop_front());
    step(1'b1, 2'b01, 8'h0F, 8'h03, 1'b0, 8'h00, 1'b0);
    exp_v = sb.pop_front();
    obs_v = observed();
    n_checks++;
    if (obs_v !== exp_v || m_q !== 8'h0C || err !== 1'b1) begin
      n_errors++;
      $display("FAIL sr_illegal: got %h expected %h (m_q %h want 0c)", obs_v, exp_v, m_q);
    end
    step(1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    exp_v = sb.pop_front();
    obs_v = observed();
    n_checks++;
    if (obs_v !== exp_v || err !== 1'b1) begin
      n_errors++;
      $display("FAIL sr_err_sticky: got %h expected %h", obs_v, exp_v);
    end
    step(1'b1, 2'b01, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    exp_v = sb.pop_front();
    obs_v = observed();
    n_checks++;
    if (obs_v !== exp_v || err !== 1'b1) begin
      n_errors++;
      $display("FAIL sr_set_wins: got %h expected %h", obs_v, exp_v);
    end
    step(1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    exp_v = sb.pop_front();
    obs_v = observed();
    n_checks++;
    if (obs_v !== exp_v || err !== 1'b0) begin
      n_errors++;
      $display("FAIL sr_err_clear: got %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic test_load_priority();
    logic err_before;
    err_before = mdl_err;
    step(1'b1, 2'b10, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0);
    exp_v = sb.pop_front();
    obs_v = observed();
    n_checks++;
    if (obs_v !== exp_v || m_q !== 8'hA5 || err !== err_before) begin
      n_errors++;
      $display("FAIL load_master: got %h expected %h", obs_v, exp_v);
    end
    step(1'b0, 2'b10, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    exp_v = sb.pop_front();
    obs_v = observed();
    n_checks++;
    if (obs_v !== exp_v || q !== 8'hA5 || q_bar !== 8'h5A) begin
      n_errors++;
      $display("FAIL load_slave: got %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic test_mode_switch();
    logic [7:0] want_m [3];
    want_m[0] = 8'h3C; want_m[1] = 8'h33; want_m[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: step(1'b1, 2'b10, 8'h3C, 8'hFF, 1'b0, 8'h00, 1'b0);
        1: step(1'b1, 2'b11, 8'h0F, 8'hFF, 1'b0, 8'h00, 1'b0);
        default: step(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
      endcase
      exp_v = sb.pop_front();
      obs_v = observed();
      n_checks++;
      if (obs_v !== exp_v || m_q !== want_m[i]) begin
        n_errors++;
        $display("FAIL mode_switch[%0d]: got %h expected %h (m_q %h want %h)", i, obs_v, exp_v, m_q, want_m[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 8'hAA, 1'b0);
    void'(sb.pop_front());
    step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 8'h55, 1'b0);
    exp_v = sb.pop_front();
    obs_v = observed();
    n_checks++;
    if (obs_v !== exp_v || m_q !== 8'h55 || q !== 8'hAA) begin
      n_errors++;
      $display("FAIL reset_mid_setup: got %h expected %h", obs_v, exp_v);
    end
    ld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (m_q !== 8'h00 || q !== 8'h00 || chg !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_mid_async: got m_q %h q %h chg %h expected 00 00 00", m_q, q, chg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      exp_v = sb.pop_front();
      obs_v = observed();
      n_checks++;
      if (obs_v !== exp_v || q === 8'h55 || chg !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_mid_after[%0d]: got %h expected %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      exp_v = sb.pop_front();
      obs_v = observed();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jk_toggle();
    test_sr_illegal();
    test_load_priority();
    test_mode_switch();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
